pll_lock_ctrl: RTL and testbench

Parametrised PLL supervisor that sits between the board reset and every `GTP_PLL_E3` wrapper in the design. It runs on the PLL reference clock and drives the PLL reset pulse. It filters the raw lock flag, retries on lock timeout and reports a permanent failure after a set number of retries. Once the lock is stable it releases `NUM_RST` downstream reset channels one at a time, and it re-asserts all of them immediately if the lock is lost.

---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and width helper for the PLL lock supervisor.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      PRST,
      WAIT,
      FILT,
      REL,
      RUN,
      FAIL
   } state_e;

   // Ceiling log2 with a floor of 1 so zero-width vectors never appear.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; 2-cycle latency.
// Free-running, no backpressure; resets to 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL supervisor: reset pulse, lock filter with timeout/retry, staged downstream reset release.
// All outputs registered; lock is accepted LOCK_FILT_CYC+1 edges after raw lock is first sampled high.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int LOCK_FILT_CYC    = 256,
   parameter int MAX_RETRY        = 3,
   parameter int NUM_RST          = 4,
   parameter int STAGE_GAP_CYC    = 64
) (
   input  logic                              clkin1,
   input  logic                              rst_n,
   input  logic                              soft_rst,
   input  logic                              pll_lock,
   output logic                              pll_rst,
   output logic [NUM_RST-1:0]                rst_out_n,
   output logic                              locked,
   output logic                              fail,
   output logic [clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

   localparam int MAX_AB = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
   localparam int MAX_CD = (LOCK_FILT_CYC > STAGE_GAP_CYC) ? LOCK_FILT_CYC : STAGE_GAP_CYC;
   localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = clog2(MAXC + 1);
   localparam int SW     = clog2(NUM_RST + 1);
   localparam int RW     = clog2(MAX_RETRY + 1);

   logic lock_s;

   sync_2ff u_lock_sync (
      .clk_i   (clkin1),
      .rst_n_i (rst_n),
      .d_i     (pll_lock),
      .q_o     (lock_s)
   );

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SW-1:0]        stg_q, stg_d;
   logic                 pll_rst_q, pll_rst_d;
   logic [NUM_RST-1:0]   rst_out_n_q, rst_out_n_d;
   logic                 locked_q, locked_d;
   logic                 fail_q, fail_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic [RW-1:0]        retry_inc;
   logic                 go_lock;
   logic                 go_lose;

   always_ff @(posedge clkin1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PRST;
         cnt_q       <= '0;
         stg_q       <= '0;
         pll_rst_q   <= 1'b1;
         rst_out_n_q <= '0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
         retry_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stg_q       <= stg_d;
         pll_rst_q   <= pll_rst_d;
         rst_out_n_q <= rst_out_n_d;
         locked_q    <= locked_d;
         fail_q      <= fail_d;
         retry_q     <= retry_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stg_d       = stg_q;
      pll_rst_d   = pll_rst_q;
      rst_out_n_d = rst_out_n_q;
      locked_d    = locked_q;
      fail_d      = fail_q;
      retry_d     = retry_q;
      go_lock     = 1'b0;
      go_lose     = 1'b0;
      retry_inc   = retry_q + RW'(1);

      case (state_q)
         PRST: begin
            if (cnt_q == CW'(RST_PULSE_CYC - 1)) begin
               state_d   = WAIT;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT: begin
            // Timeout outranks a lock seen on the same edge.
            if (cnt_q == CW'(LOCK_TIMEOUT_CYC - 1)) begin
               retry_d   = retry_inc;
               pll_rst_d = 1'b1;
               cnt_d     = '0;
               if (retry_inc == RW'(MAX_RETRY)) begin
                  state_d = FAIL;
                  fail_d  = 1'b1;
               end else begin
                  state_d = PRST;
               end
            end else if (lock_s) begin
               if (LOCK_FILT_CYC == 1) begin
                  go_lock = 1'b1;
               end else begin
                  state_d = FILT;
                  cnt_d   = CW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FILT: begin
            if (!lock_s) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_FILT_CYC - 1)) begin
               go_lock = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         REL: begin
            if (!lock_s) begin
               go_lose = 1'b1;
            end else if (cnt_q == CW'(STAGE_GAP_CYC - 1)) begin
               cnt_d = '0;
               stg_d = stg_q + SW'(1);
               for (int i = 0; i < NUM_RST; i++) begin
                  if (stg_q == SW'(i)) rst_out_n_d[i] = 1'b1;
               end
               if (stg_q == SW'(NUM_RST - 1)) state_d = RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (!lock_s) go_lose = 1'b1;
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = PRST;
         end
      endcase

      if (go_lock) begin
         state_d        = (NUM_RST == 1) ? RUN : REL;
         cnt_d          = '0;
         stg_d          = SW'(1);
         rst_out_n_d    = '0;
         rst_out_n_d[0] = 1'b1;
         locked_d       = 1'b1;
         retry_d        = '0;
      end

      if (go_lose) begin
         state_d     = PRST;
         cnt_d       = '0;
         stg_d       = '0;
         pll_rst_d   = 1'b1;
         rst_out_n_d = '0;
         locked_d    = 1'b0;
      end

      if (soft_rst) begin
         state_d     = PRST;
         cnt_d       = '0;
         stg_d       = '0;
         pll_rst_d   = 1'b1;
         rst_out_n_d = '0;
         locked_d    = 1'b0;
         fail_d      = 1'b0;
         retry_d     = '0;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign rst_out_n = rst_out_n_q;
   assign locked    = locked_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: edge-indexed reference model checked every cycle plus directed literal checks.
module tb_pll_lock_ctrl;

   localparam int PULSE = 4;
   localparam int TO    = 100;
   localparam int FILTN = 8;
   localparam int NR    = 3;
   localparam int GAP   = 5;
   localparam int MAXR  = 2;

   localparam int M_PULSE = 0;
   localparam int M_SEEK  = 1;
   localparam int M_UP    = 2;
   localparam int M_FAIL  = 3;

   logic          clk;
   logic          rst_n;
   logic          soft_rst;
   logic          pll_lock;
   logic          pll_rst;
   logic [NR-1:0] rst_out_n;
   logic          locked;
   logic          fail;
   logic [1:0]    retry_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pll_lock_ctrl #(
      .RST_PULSE_CYC    (PULSE),
      .LOCK_TIMEOUT_CYC (TO),
      .LOCK_FILT_CYC    (FILTN),
      .MAX_RETRY        (MAXR),
      .NUM_RST          (NR),
      .STAGE_GAP_CYC    (GAP)
   ) dut (
      .clkin1    (clk),
      .rst_n     (rst_n),
      .soft_rst  (soft_rst),
      .pll_lock  (pll_lock),
      .pll_rst   (pll_rst),
      .rst_out_n (rst_out_n),
      .locked    (locked),
      .fail      (fail),
      .retry_cnt (retry_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model in terms of edge numbers: m_n is the count of edges since rst_n release.
   int   m_n, m_mode, m_start, m_dead, m_streak, m_retry, m_lockedge;
   logic h1, h2, ls;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_mode = M_PULSE; m_start = 0; m_dead = 0;
         m_streak = 0; m_retry = 0; m_lockedge = 0;
         h1 = 1'b0; h2 = 1'b0;
      end else begin
         m_n = m_n + 1;
         ls  = h2;
         h2  = h1;
         h1  = pll_lock;
         if (soft_rst) begin
            m_mode = M_PULSE; m_start = m_n; m_retry = 0;
         end else begin
            case (m_mode)
               M_PULSE: if (m_n == m_start + PULSE) begin
                  m_mode = M_SEEK; m_dead = m_n + TO; m_streak = 0;
               end
               M_SEEK: begin
                  if (m_streak == 0 && m_n == m_dead) begin
                     m_retry = m_retry + 1;
                     if (m_retry == MAXR) m_mode = M_FAIL;
                     else begin m_mode = M_PULSE; m_start = m_n; end
                  end else if (ls) begin
                     m_streak = m_streak + 1;
                     if (m_streak == FILTN) begin
                        m_mode = M_UP; m_lockedge = m_n; m_retry = 0;
                     end
                  end else if (m_streak > 0) begin
                     m_streak = 0; m_dead = m_n + TO;
                  end
               end
               M_UP: if (!ls) begin m_mode = M_PULSE; m_start = m_n; end
               default: ;
            endcase
         end
      end
   end

   logic [NR+4:0] exp_vec, got_vec;
   always @(negedge clk) begin
      exp_vec[NR+4] = (m_mode == M_PULSE) || (m_mode == M_FAIL);
      for (int k = 0; k < NR; k++)
         exp_vec[4+k] = (m_mode == M_UP) && (m_n >= m_lockedge + k * GAP);
      exp_vec[3]   = (m_mode == M_UP);
      exp_vec[2]   = (m_mode == M_FAIL);
      exp_vec[1:0] = 2'(m_retry);
      got_vec = {pll_rst, rst_out_n, locked, fail, retry_cnt};
      n_tests++;
      if (got_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL model_cmp edge=%0d {pll_rst,rst_out_n,locked,fail,retry} got=%b exp=%b",
                  m_n, got_vec, exp_vec);
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0d exp=%0d", nm, m_n, got, exp);
      end
   endtask

   // Leaves time 1 unit after edge e.
   task automatic wait_to(input int e);
      int guard;
      guard = 0;
      while (m_n < e && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (m_n < e) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_to_timeout got=%0d exp=%0d", m_n, e);
      end
   endtask

   // Makes v the raw lock value first sampled at edge e.
   task automatic lock_at(input int e, input logic v);
      wait_to(e - 1);
      #1 pll_lock = v;
   endtask

   task automatic soft_at(input int e);
      wait_to(e - 1);
      #1 soft_rst = 1'b1;
      wait_to(e);
      #1 soft_rst = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      soft_rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; pll_lock = 1'b0; soft_rst = 1'b0;

      // Clean lock
      do_reset();
      wait_to(0);
      chk("reset_pll_rst", int'(pll_rst), 1);
      chk("reset_rst_out_n", int'(rst_out_n), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_fail", int'(fail), 0);
      chk("reset_retry", int'(retry_cnt), 0);
      wait_to(3);  chk("pulse_seen_edge4", int'(pll_rst), 1);
      wait_to(4);  chk("pulse_gone_edge5", int'(pll_rst), 0);
      lock_at(20, 1'b1);
      wait_to(28); chk("clean_locked_e28", int'(locked), 0);
      wait_to(29); chk("clean_locked_e29", int'(locked), 1);
                   chk("clean_rst_e29", int'(rst_out_n), 1);
      wait_to(33); chk("clean_rst_e33", int'(rst_out_n), 1);
      wait_to(34); chk("clean_rst_e34", int'(rst_out_n), 3);
      wait_to(38); chk("clean_rst_e38", int'(rst_out_n), 3);
      wait_to(39); chk("clean_rst_e39", int'(rst_out_n), 7);

      // Glitchy lock: high 20..24, low 25, high from 26
      do_reset();
      lock_at(20, 1'b1);
      lock_at(25, 1'b0);
      lock_at(26, 1'b1);
      wait_to(29); chk("glitch_locked_e29", int'(locked), 0);
      wait_to(34); chk("glitch_locked_e34", int'(locked), 0);
      wait_to(35); chk("glitch_locked_e35", int'(locked), 1);

      // Timeouts into FAIL, then soft_rst
      do_reset();
      wait_to(103); chk("to_retry_e103", int'(retry_cnt), 0);
                    chk("to_pll_rst_e103", int'(pll_rst), 0);
      wait_to(104); chk("to_retry_e104", int'(retry_cnt), 1);
                    chk("to_pll_rst_e104", int'(pll_rst), 1);
      wait_to(108); chk("to_pll_rst_e108", int'(pll_rst), 0);
      wait_to(207); chk("to_fail_e207", int'(fail), 0);
      wait_to(208); chk("to_fail_e208", int'(fail), 1);
                    chk("to_retry_e208", int'(retry_cnt), 2);
      wait_to(250); chk("to_fail_held", int'(fail), 1);
                    chk("to_pll_rst_held", int'(pll_rst), 1);
      soft_at(251);
      chk("soft_fail_clr", int'(fail), 0);
      chk("soft_retry_clr", int'(retry_cnt), 0);
      chk("soft_pll_rst", int'(pll_rst), 1);
      wait_to(254); chk("soft_pulse_e254", int'(pll_rst), 1);
      wait_to(255); chk("soft_pulse_e255", int'(pll_rst), 0);

      // Lock loss in RUN
      do_reset();
      lock_at(20, 1'b1);
      wait_to(39); chk("run_rst_e39", int'(rst_out_n), 7);
      lock_at(45, 1'b0);
      lock_at(46, 1'b1);
      wait_to(46); chk("loss_rst_e46", int'(rst_out_n), 7);
      wait_to(47); chk("loss_rst_e47", int'(rst_out_n), 0);
                   chk("loss_locked_e47", int'(locked), 0);
                   chk("loss_pll_rst_e47", int'(pll_rst), 1);
      wait_to(59); chk("relock_e59", int'(locked), 1);
                   chk("relock_rst_e59", int'(rst_out_n), 1);
      wait_to(69); chk("relock_rst_e69", int'(rst_out_n), 7);

      // Lock loss mid-REL after 011
      do_reset();
      lock_at(20, 1'b1);
      wait_to(34); chk("rel_rst_e34", int'(rst_out_n), 3);
      lock_at(36, 1'b0);
      wait_to(37); chk("rel_rst_e37", int'(rst_out_n), 3);
      wait_to(38); chk("rel_rst_e38", int'(rst_out_n), 0);
      wait_to(45); chk("rel_rst_e45", int'(rst_out_n), 0);

      // soft_rst and lock loss together in RUN
      do_reset();
      lock_at(20, 1'b1);
      lock_at(43, 1'b0);
      lock_at(44, 1'b1);
      soft_at(45);
      chk("both_rst_e45", int'(rst_out_n), 0);
      chk("both_retry_e45", int'(retry_cnt), 0);
      chk("both_pll_rst_e45", int'(pll_rst), 1);
      wait_to(56); chk("both_locked_e56", int'(locked), 0);
      wait_to(57); chk("both_locked_e57", int'(locked), 1);

      // Asynchronous reset in REL
      do_reset();
      lock_at(20, 1'b1);
      wait_to(31); chk("arst_pre_rst", int'(rst_out_n), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pll_rst", int'(pll_rst), 1);
      chk("arst_rst_out_n", int'(rst_out_n), 0);
      chk("arst_locked", int'(locked), 0);
      chk("arst_retry", int'(retry_cnt), 0);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
